// File: rtl/kanade32_mmio_uart_tx.sv
// kanade32_mmio_uart_tx
// Memory-mapped 8N1 UART transmitter sitting beside the data RAM.
// Registers (word offsets from BASE):
//   0 TXDATA  write-only, pushes data[7:0] into the TX FIFO
//   1 STATUS  {25'b0, overflow, count[3:0], empty, full}; any write clears overflow
//   2 DIV     baud divisor, each serial bit lasts div+1 clocks
//   3 reserved
// q follows the RAM's one-cycle read latency and is zero when not selected,
// so the core can simply OR it with the RAM output.
module kanade32_mmio_uart_tx #(
    parameter logic [29:0] BASE      = 30'h3FFF_FF00,
    parameter int          DEPTH     = 8,
    parameter logic [15:0] DIV_RESET = 16'd433
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [29:0] address,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q,
    output logic        txd,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       sel;
    logic [1:0] off;
    logic       wr_sel;

    assign sel    = (address[29:2] == BASE[29:2]);
    assign off    = address[1:0];
    assign wr_sel = wren && sel;

    // Upper write-data bits have no destination in this block.
    logic unused_data_hi;
    assign unused_data_hi = ^data[31:16];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   div;

    tx_state_t     state;
    logic [7:0]    shift;
    logic [2:0]    bitcnt;
    logic [15:0]   timer;

    logic          full;
    logic          empty;
    logic          push_req;
    logic          push;
    logic          pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_req = wr_sel && (off == 2'd0);
    // A push is judged against the registered count only; a same-cycle pop
    // does not make room for a push into a full FIFO.
    assign push     = push_req && !full;
    assign pop      = (state == ST_IDLE) && !empty;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [3:0]  count_sat;
    logic [31:0] status;
    logic [31:0] rd_val;

    // Saturate the FIFO count into the 4-bit STATUS field.
    always_comb begin
        count_sat = 4'hF;
        if (32'(count) <= 32'd15) begin
            count_sat = 4'(count);
        end
    end

    assign status = {25'b0, overflow, count_sat, empty, full};

    // Select the register value addressed by the low word-address bits.
    always_comb begin
        // NOTE: assigning a default first means every path writes rd_val,
        // so no latch is inferred when a case arm is missing.
        rd_val = '0;
        case (off)
            2'd1:    rd_val = status;
            2'd2:    rd_val = {16'b0, div};
            default: rd_val = '0;
        endcase
    end

    // Registered read data, one-cycle latency, zero when not selected.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            q <= '0;
        end else begin
            q <= sel ? rd_val : '0;
        end
    end

    // ------------------------------------------------------------------
    // Control registers: divisor and sticky overflow flag
    // ------------------------------------------------------------------
    // Divisor write and overflow set/clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div      <= DIV_RESET;
            overflow <= 1'b0;
        end else begin
            if (wr_sel && (off == 2'd2)) begin
                div <= data[15:0];
            end
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (wr_sel && (off == 2'd1)) begin
                overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    // FIFO storage array, written on accepted pushes.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; only pointers and count do,
        // which is enough to make stale contents unreachable.
        if (push) begin
            mem[wr_ptr] <= data[7:0];
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serialiser: IDLE -> START -> DATA x8 -> STOP, txd and irq registered
    // ------------------------------------------------------------------
    // Transmit FSM; the bit timer reloads from div at each bit start, so a
    // divisor change only affects bits that begin after it is written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            shift  <= '0;
            bitcnt <= '0;
            timer  <= '0;
            txd    <= 1'b1;
            irq    <= 1'b1;
        end else begin
            irq <= empty && (state == ST_IDLE);
            case (state)
                ST_IDLE: begin
                    txd <= 1'b1;
                    if (!empty) begin
                        shift <= mem[rd_ptr];
                        timer <= div;
                        txd   <= 1'b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (timer == 16'd0) begin
                        timer  <= div;
                        bitcnt <= 3'd0;
                        txd    <= shift[0];
                        state  <= ST_DATA;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (timer == 16'd0) begin
                        timer  <= div;
                        shift  <= shift >> 1;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            txd   <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            txd <= shift[1];
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                ST_STOP: begin
                    txd <= 1'b1;
                    if (timer == 16'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kanade32_mmio_uart_tx.sv
// tb_kanade32_mmio_uart_tx
// Directed bench for the MMIO UART transmitter: register reads, frame timing,
// FIFO full/overflow behaviour, async reset mid-frame and divisor changes.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_kanade32_mmio_uart_tx;

    localparam logic [29:0] BASE   = 30'h3FFF_FF00;
    localparam logic [29:0] A_TX   = BASE;
    localparam logic [29:0] A_STAT = BASE + 30'd1;
    localparam logic [29:0] A_DIV  = BASE + 30'd2;
    localparam logic [29:0] A_RSV  = BASE + 30'd3;

    logic        clk;
    logic        reset_n;
    logic [29:0] address;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q;
    logic        txd;
    logic        irq;

    int n_checks;
    int n_errors;

    kanade32_mmio_uart_tx #(
        .BASE      (BASE),
        .DEPTH     (8),
        .DIV_RESET (16'd433)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .address (address),
        .data    (data),
        .wren    (wren),
        .q       (q),
        .txd     (txd),
        .irq     (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic bus_write(input logic [29:0] a, input logic [31:0] d);
        address = a;
        data    = d;
        wren    = 1'b1;
        @(negedge clk);
        wren    = 1'b0;
    endtask

    // Called at a falling edge; q is sampled one clock later.
    task automatic bus_read(input logic [29:0] a, output logic [31:0] v);
        address = a;
        wren    = 1'b0;
        @(negedge clk);
        v = q;
    endtask

    // Receive one 8N1 byte with p clocks per bit; ok = stop bit seen and no timeout.
    task automatic uart_recv(input int p, output logic [7:0] b, output logic ok);
        int n;
        ok = 1'b0;
        b  = '0;
        n  = 0;
        @(negedge clk);
        while (txd !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) return;
        for (int k = 0; k < 8; k++) begin
            repeat (p) @(negedge clk);
            b[k] = txd;
        end
        repeat (p) @(negedge clk);
        ok = (txd === 1'b1);
    endtask

    logic [31:0] v;
    logic [7:0]  tbl [9];
    logic        samp [76];
    int          bad;

    initial begin
        n_checks = 0;
        n_errors = 0;
        tbl[0] = 8'h31; tbl[1] = 8'hC5; tbl[2] = 8'h00;
        tbl[3] = 8'hFF; tbl[4] = 8'h5A; tbl[5] = 8'hA5;
        tbl[6] = 8'h81; tbl[7] = 8'h7E; tbl[8] = 8'h13;

        address = '0;
        data    = '0;
        wren    = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_irq", 32'(irq), 32'd1);
        check("rst_q", q, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset values and decode
        bus_read(A_STAT, v); check("status_reset", v, 32'h0000_0002);
        bus_read(A_DIV, v);  check("div_reset", v, 32'h0000_01B1);
        bus_read(A_RSV, v);  check("reserved_read", v, 32'd0);
        bus_read(A_TX, v);   check("txdata_read", v, 32'd0);
        bus_read(30'h0000_0010, v); check("unsel_read", v, 32'd0);
        bus_write(30'h0000_0010, 32'h0000_00AA);
        bus_write(30'h0000_0012, 32'h0000_0007);
        bus_read(A_DIV, v);  check("unsel_div_kept", v, 32'h0000_01B1);
        bus_read(A_STAT, v); check("unsel_fifo_kept", v, 32'h0000_0002);
        check("unsel_txd_idle", 32'(txd), 32'd1);

        // DIV=3 frame of 0x55: 10 bits x 4 clocks
        bus_write(A_DIV, 32'd3);
        bus_read(A_DIV, v); check("div_write", v, 32'd3);
        bus_write(A_TX, 32'h0000_0055);
        check("irq_pre_pop", 32'(irq), 32'd1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            logic exp_bit;
            int   bi;
            @(negedge clk);
            if (i == 0) check("irq_fell", 32'(irq), 32'd0);
            bi = i / 4;
            if (bi == 0)      exp_bit = 1'b0;
            else if (bi == 9) exp_bit = 1'b1;
            else              exp_bit = (bi % 2 == 1);
            if (txd !== exp_bit) bad++;
        end
        check("frame55_bits_wrong", 32'(bad), 32'd0);
        @(negedge clk);
        check("irq_still_low", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_rose", 32'(irq), 32'd1);
        bus_read(A_STAT, v); check("status_after_frame", v, 32'h0000_0002);

        // DIV=0, nine back-to-back bytes, overflow on the tenth
        bus_write(A_DIV, 32'd0);
        fork
            begin
                for (int i = 0; i < 9; i++) bus_write(A_TX, {24'd0, tbl[i]});
                bus_read(A_STAT, v); check("status_full", v, 32'h0000_0021);
                bus_write(A_TX, 32'h0000_00EE);
                bus_read(A_STAT, v); check("status_overflow", v, 32'h0000_0061);
                bus_write(A_STAT, 32'd0);
                bus_read(A_STAT, v); check("status_ovf_cleared", v, 32'h0000_001C);
            end
            begin
                for (int i = 0; i < 9; i++) begin
                    logic [7:0] b;
                    logic       ok;
                    uart_recv(1, b, ok);
                    check("rx_stop_ok", 32'(ok), 32'd1);
                    check("rx_byte", 32'(b), 32'(tbl[i]));
                end
            end
        join
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) bad++;
        end
        check("no_dropped_byte_sent", 32'(bad), 32'd0);
        bus_read(A_STAT, v); check("status_drained", v, 32'h0000_0002);

        // DIV 3 -> 7 written during the start bit
        bus_write(A_DIV, 32'd3);
        bus_write(A_TX, 32'h0000_000F);
        fork
            begin
                for (int i = 0; i < 76; i++) begin
                    @(negedge clk);
                    samp[i] = txd;
                end
            end
            begin
                @(negedge clk);
                bus_write(A_DIV, 32'd7);
            end
        join
        bad = 0;
        for (int i = 0; i < 76; i++) begin
            logic exp_bit;
            if (i < 4)       exp_bit = 1'b0;
            else if (i < 36) exp_bit = 1'b1;
            else if (i < 68) exp_bit = 1'b0;
            else             exp_bit = 1'b1;
            if (samp[i] !== exp_bit) bad++;
        end
        check("div_change_bits_wrong", 32'(bad), 32'd0);

        // Reset during DATA bit 3 with a second byte queued
        bus_write(A_DIV, 32'd3);
        bus_write(A_TX, 32'h0000_0000);
        bus_write(A_TX, 32'h0000_0000);
        repeat (16) @(negedge clk);
        check("mid_bit3_txd_low", 32'(txd), 32'd0);
        reset_n = 1'b0;
        #1;
        check("async_rst_txd", 32'(txd), 32'd1);
        check("async_rst_irq", 32'(irq), 32'd1);
        check("async_rst_q", q, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(A_STAT, v); check("status_after_reset", v, 32'h0000_0002);
        bus_read(A_DIV, v);  check("div_after_reset", v, 32'h0000_01B1);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) bad++;
        end
        check("no_residual_frame", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/kanade32_mmio_uart_tx.md
Name: kanade32_mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the KANADE32 data-memory port, downstream of the memory-access stage and alongside the RAM.
- Receives the same word address, write data and write enable that the core drives to the RAM.
- Returns read data with the same 1-cycle latency as the synchronous RAM. The top level ORs its q with the RAM q.
- Buffers bytes in a small FIFO and serialises them 8N1 on txd, so store-word sequences never stall the pipeline.

Parameters:
- BASE, 30'h3FFF_FF00: word address of register offset 0 (byte address 0xFFFF_FC00). Offsets 0..3 are decoded; BASE[1:0] must be 0.
- DEPTH, 8: TX FIFO depth in bytes. Power of two, minimum 2.
- DIV_RESET, 16'd433: reset value of the baud divisor.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- address  input  30  word address (the core's byte address bits [31:2])
- data  input  32  write data
- wren  input  1  write strobe for this cycle
- q  output  32  registered read data; 0 when the previous-cycle address was not selected
- txd  output  1  serial output, idle high
- irq  output  1  high while the FIFO is empty and the transmitter is idle

Behaviour:
- sel = (address[29:2] == BASE[29:2]); off = address[1:0].
- Register map:
  - off 0 TXDATA (write-only): push data[7:0]. Reads return 0.
  - off 1 STATUS: read {25'b0, overflow, count[3:0], empty, full}, where bit0 = full, bit1 = empty, bits[5:2] = count (saturating at 15), bit6 = overflow. Any write clears overflow.
  - off 2 DIV: read/write bits [15:0]. Reads return {16'b0, div}.
  - off 3: reserved. Reads 0, writes ignored.
- Read path: q <= (sel ? regval(off) : 0) on every clock. Read latency is exactly 1 cycle. No read side effects.
- Writes take effect at the clock edge where wren && sel.
- Push accepted iff the FIFO is not full, using the registered count.
- A push to a full FIFO is dropped and sets overflow (sticky).
- Same-cycle push and pop with the FIFO non-full: both occur and count is unchanged.
- FIFO: circular buffer with read and write pointers of width log2(DEPTH) that wrap modulo DEPTH, plus a count register of width log2(DEPTH)+1.
- TX FSM, each bit lasting div+1 clocks (bit-timer reloads from div at every bit start):
  - IDLE: txd = 1. If the FIFO is non-empty, pop the head into shift[7:0] and go to START.
  - START: txd = 0 for one bit time, then DATA with bitcnt = 0.
  - DATA: txd = shift[0]. At bit end, shift >>= 1 and bitcnt++. After bit 7, go to STOP.
  - STOP: txd = 1 for one bit time, then IDLE. A pending byte therefore starts in the cycle after STOP ends, giving 1 idle clock between frames.
- A DIV write during a frame applies from the next bit start. The current bit keeps its old length.
- div = 0 is legal: 1 clock per bit.
- irq = empty && (state == IDLE), registered.
- Reset (async, any state, including mid-frame):
  - txd = 1, q = 0, irq = 1
  - FSM = IDLE
  - FIFO pointers and count = 0
  - overflow = 0
  - div = DIV_RESET
  - The partially sent frame is abandoned.
- Unselected addresses: no state change regardless of wren.

Test Plan:
- Reset, then read STATUS (address BASE+1) -> q = 32'h0000_0002 one cycle later; txd = 1; irq = 1.
- Write DIV = 3, write TXDATA = 32'h0000_0055 -> txd holds each bit for 4 clocks in the order 0 (start),1,0,1,0,1,0,1,0, then 1 (stop). Frame is 40 clocks. irq falls within 2 cycles of the push and rises after the stop bit.
- DIV = 0, write 9 bytes back-to-back while the first is still in START:
  - first byte pops immediately, so 8 remain and the FIFO is full;
  - STATUS read = 32'h0000_0021 (full, count = 8);
  - push a 10th byte -> overflow set, STATUS = 32'h0000_0061;
  - write STATUS -> overflow cleared;
  - all 9 bytes appear on txd in order.
- Read DIV at BASE+2 after reset -> q = 32'h0000_01B1. Read a non-selected address (e.g. 30'h0000_0010) -> q = 0. A write with wren=1 to a non-selected address leaves FIFO and DIV unchanged.
- Assert reset_n low during DATA bit 3 -> txd = 1 asynchronously. After release, STATUS = 32'h0000_0002 and no residual frame is sent.
- Write DIV = 7 mid-bit during a frame with DIV = 3 -> the current bit stays 4 clocks; following bits are 8 clocks.
